// File: rtl/ram_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_burst_reader                                           |
// | Description : Read-side consumer for the dual-clock width-converting     |
// |               RAM. On a start command it fetches a run of consecutive    |
// |               words (wrapping modulo DEPTH) from the RAM read port and   |
// |               streams them out as a valid/ready stream with last-beat    |
// |               marking. A 2-entry prefetch buffer hides the RAM's 1-cycle |
// |               registered read latency so one beat per cycle is sustained.|
// | Ports       : clk, rst_n          - RAM read clock, async active-low rst |
// |               start, base_addr,   - command strobe, first address and    |
// |               len                   word count (0..DEPTH)                |
// |               busy, done          - run in progress / completion pulse   |
// |               ram_rd_addr,        - RAM read address / registered data   |
// |               ram_rd_data                                                |
// |               m_valid, m_ready,   - output stream handshake, payload     |
// |               m_data, m_last        and final-beat marker                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_burst_reader #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    ram_rd_addr,
    input  logic [WIDTH-1:0] ram_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    localparam logic [1:0]    c_S_IDLE   = 2'd0;
    localparam logic [1:0]    c_S_RUN    = 2'd1;
    localparam logic [1:0]    c_S_DONE   = 2'd2;

    localparam logic [AW-1:0] c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_LEN_ZERO = '0;
    localparam logic [AW:0]   c_LEN_ONE  = {{AW{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [AW-1:0]    r_addr;
    logic [AW:0]      r_issue_left;   // reads still to be issued
    logic [AW:0]      r_out_left;     // beats still to be handshaken
    logic             r_inflight;     // a read was issued last cycle
    logic [1:0]       r_buf_cnt;
    logic [WIDTH-1:0] r_head;         // buffer head doubles as m_data
    logic [WIDTH-1:0] r_tail;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic             w_accept;
    logic [2:0]       w_occ;

    assign w_pop    = m_valid & m_ready;
    assign w_push   = r_inflight;
    assign w_accept = (r_state == c_S_IDLE) && start && (len != c_LEN_ZERO);

    // Occupancy the buffer will have once the pending read lands and this
    // cycle's pop retires. A new read is only allowed if it still fits,
    // which is what makes overflow impossible. pop implies buf_cnt >= 1,
    // so the subtraction cannot underflow.
    assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == c_S_RUN) && (r_issue_left != c_LEN_ZERO)
                     && (w_occ < 3'd2);

    assign ram_rd_addr = r_addr;
    assign m_data      = r_head;
    assign m_valid     = (r_buf_cnt != 2'd0);
    assign m_last      = m_valid && (r_out_left == c_LEN_ONE);
    assign busy        = (r_state == c_S_RUN);
    assign done        = (r_state == c_S_DONE);

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        // A zero-length run completes without touching the RAM.
                        r_state <= (len == c_LEN_ZERO) ? c_S_DONE : c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    if (w_pop && m_last) begin
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Read address and run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_out_left   <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_addr       <= base_addr;
                r_issue_left <= len;
                r_out_left   <= len;
            end else begin
                if (w_issue) begin
                    // AW-bit addition wraps DEPTH-1 back to 0.
                    r_addr       <= r_addr + c_ADDR_ONE;
                    r_issue_left <= r_issue_left - c_LEN_ONE;
                end
                if (w_pop) begin
                    r_out_left <= r_out_left - c_LEN_ONE;
                end
            end
        end
    end

    // Two-entry prefetch buffer. The head register is the stream payload,
    // so it only changes on a pop or when the buffer is empty, which keeps
    // m_data stable through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_cnt <= 2'd0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_head <= ram_rd_data;
                    end else begin
                        r_tail <= ram_rd_data;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_buf_cnt == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_buf_cnt == 2'd1) begin
                        r_head <= ram_rd_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= ram_rd_data;
                    end
                end
                default: begin
                    r_buf_cnt <= r_buf_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
